// File: rtl/fir_decim.sv
// 4-tap FIR filter with integer decimation.
// Each product is reduced to S(16,15) with saturation, the four taps are summed
// at full precision, and one output is registered on every DECIM-th accepted sample.
module fir_decim #(
   parameter int unsigned NB_INPUT  = 16,
   parameter int unsigned NB_OUTPUT = 18,
   parameter int unsigned DECIM     = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic signed [NB_INPUT-1:0]  i_data,
   input  logic                        i_coef_we,
   input  logic        [1:0]           i_coef_addr,
   input  logic signed [15:0]          i_coef_data,
   input  logic                        i_sat_clr,
   output logic signed [NB_OUTPUT-1:0] o_data,
   output logic                        o_valid,
   output logic                        o_sat
);

   localparam int unsigned NB_COEF  = 16;
   localparam int unsigned NB_TAP   = 16;
   localparam int unsigned NB_PROD  = NB_INPUT + NB_COEF;
   localparam int unsigned NTAPS    = 4;
   localparam int unsigned NB_PHASE = (DECIM > 2) ? $clog2(DECIM) : 1;

   localparam logic signed [NB_COEF-1:0] H_OUTER_RST = 16'sh04F0;
   localparam logic signed [NB_COEF-1:0] H_INNER_RST = 16'sh3B0F;
   localparam logic signed [NB_TAP-1:0]  TAP_MAX     = 16'sh7FFF;
   localparam logic signed [NB_TAP-1:0]  TAP_MIN     = 16'sh8000;
   localparam logic [NB_PHASE-1:0]       PHASE_LAST  = NB_PHASE'(DECIM - 1);

   logic signed [NB_COEF-1:0]   coef_q [NTAPS];
   logic signed [NB_COEF-1:0]   coef_d [NTAPS];
   logic signed [NB_INPUT-1:0]  dly_q  [NTAPS-1];
   logic signed [NB_INPUT-1:0]  dly_d  [NTAPS-1];
   logic        [NB_PHASE-1:0]  phase_q, phase_d;
   logic signed [NB_OUTPUT-1:0] data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        sat_q, sat_d;

   logic signed [NB_INPUT-1:0]  x_c      [NTAPS];
   logic signed [NB_PROD-1:0]   prod_c   [NTAPS];
   logic signed [NB_TAP-1:0]    tap_c    [NTAPS];
   logic                        any_sat_c;
   logic signed [NB_OUTPUT-1:0] sum_c;
   logic                        fire_c;

   // Tap products, reduction to S(16,15) with saturation, and full-precision sum
   always_comb begin
      x_c[0]    = i_data;
      for (int k = 1; k < NTAPS; k++) begin
         x_c[k] = dly_q[k-1];
      end
      any_sat_c = 1'b0;
      sum_c     = '0;
      for (int k = 0; k < NTAPS; k++) begin
         prod_c[k] = NB_PROD'(coef_q[k]) * NB_PROD'(x_c[k]);
         if (prod_c[k][NB_PROD-1] != prod_c[k][NB_PROD-2]) begin
            tap_c[k]  = prod_c[k][NB_PROD-1] ? TAP_MIN : TAP_MAX;
            any_sat_c = 1'b1;
         end else begin
            tap_c[k]  = prod_c[k][NB_PROD-2 -: NB_TAP];
         end
         sum_c = sum_c + NB_OUTPUT'(tap_c[k]);
      end
   end

   // Next-state: delay line, phase, output capture, sticky saturation, coefficient writes
   always_comb begin
      coef_d  = coef_q;
      dly_d   = dly_q;
      phase_d = phase_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sat_d   = sat_q & ~i_sat_clr;
      fire_c  = i_valid && (phase_q == PHASE_LAST);

      if (i_valid) begin
         dly_d[0] = i_data;
         for (int k = 1; k < NTAPS - 1; k++) begin
            dly_d[k] = dly_q[k-1];
         end
         phase_d = fire_c ? '0 : phase_q + NB_PHASE'(1);
      end

      // Output uses the pre-shift delay line; saturation on this sample wins over clear
      if (fire_c) begin
         data_d  = sum_c;
         valid_d = 1'b1;
         if (any_sat_c) begin
            sat_d = 1'b1;
         end
      end

      // Written coefficient takes effect from the following edge
      if (i_coef_we) begin
         coef_d[i_coef_addr] = i_coef_data;
      end
   end

   // State registers with asynchronous reset to the default symmetric filter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         coef_q[0] <= H_OUTER_RST;
         coef_q[1] <= H_INNER_RST;
         coef_q[2] <= H_INNER_RST;
         coef_q[3] <= H_OUTER_RST;
         for (int k = 0; k < NTAPS - 1; k++) begin
            dly_q[k] <= '0;
         end
         phase_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         coef_q  <= coef_d;
         dly_q   <= dly_d;
         phase_q <= phase_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_decim.sv
// Testbench for fir_decim: directed and randomized steps checked against an
// arithmetic reference model of the filter/decimator.
module tb_fir_decim;

   localparam int unsigned NB_INPUT  = 16;
   localparam int unsigned NB_OUTPUT = 18;
   localparam int unsigned DECIM     = 4;

   logic                        i_clk;
   logic                        i_rst_n;
   logic                        i_valid;
   logic signed [NB_INPUT-1:0]  i_data;
   logic                        i_coef_we;
   logic        [1:0]           i_coef_addr;
   logic signed [15:0]          i_coef_data;
   logic                        i_sat_clr;
   logic signed [NB_OUTPUT-1:0] o_data;
   logic                        o_valid;
   logic                        o_sat;

   fir_decim #(.NB_INPUT(NB_INPUT), .NB_OUTPUT(NB_OUTPUT), .DECIM(DECIM)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_coef_we  (i_coef_we),
      .i_coef_addr(i_coef_addr),
      .i_coef_data(i_coef_data),
      .i_sat_clr  (i_sat_clr),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_sat      (o_sat)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int                          coef [4];
   int                          hist [3];
   int                          phase;
   logic signed [NB_OUTPUT-1:0] exp_data;
   logic                        exp_valid;
   logic                        exp_sat;

   task automatic model_reset();
      coef[0] = 32'h04F0; coef[1] = 32'h3B0F; coef[2] = 32'h3B0F; coef[3] = 32'h04F0;
      for (int k = 0; k < 3; k++) hist[k] = 0;
      phase     = 0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_sat   = 1'b0;
   endtask

   // Exact product reduced to S(16,15): saturate outside [-2^30, 2^30), else floor(p / 2^15)
   task automatic tap(input int h, input int x, output int t, output bit s);
      int p;
      p = h * x;
      s = (p >= 32'sd1073741824) || (p < -32'sd1073741824);
      if (s) t = (p >= 0) ? 32767 : -32768;
      else   t = p >>> 15;
   endtask

   // One rising edge of the reference: uses pre-edge coefficients and history
   task automatic model_edge(input bit v, input logic signed [15:0] d, input bit we,
                             input logic [1:0] a, input logic signed [15:0] cd, input bit clr);
      int  xs [4];
      int  y, t;
      bit  s, anys, fire;
      if (!i_rst_n) return;
      xs[0] = int'(d); xs[1] = hist[0]; xs[2] = hist[1]; xs[3] = hist[2];
      y = 0; anys = 0;
      for (int k = 0; k < 4; k++) begin
         tap(coef[k], xs[k], t, s);
         y    += t;
         anys |= s;
      end
      fire      = v && (phase == DECIM - 1);
      exp_valid = fire;
      if (clr) exp_sat = 1'b0;
      if (fire) begin
         exp_data = NB_OUTPUT'(y);
         if (anys) exp_sat = 1'b1;
      end
      if (v) begin
         hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(d);
         phase   = (phase + 1) % DECIM;
      end
      if (we) coef[a] = int'(cd);
   endtask

   task automatic check(input string tag);
      n_vec++;
      assert (o_valid === exp_valid) else begin
         n_err++;
         $error("FAIL %s o_valid: got %0b expected %0b", tag, o_valid, exp_valid);
      end
      n_vec++;
      assert (o_data === exp_data) else begin
         n_err++;
         $error("FAIL %s o_data: got %h expected %h", tag, o_data, exp_data);
      end
      n_vec++;
      assert (o_sat === exp_sat) else begin
         n_err++;
         $error("FAIL %s o_sat: got %0b expected %0b", tag, o_sat, exp_sat);
      end
   endtask

   task automatic check_const(input string tag, input logic [17:0] got, input logic [17:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare against the model
   task automatic step(input string tag, input bit v, input logic signed [15:0] d,
                       input bit we = 1'b0, input logic [1:0] a = 2'd0,
                       input logic signed [15:0] cd = 16'sh0, input bit clr = 1'b0);
      i_valid = v; i_data = d; i_coef_we = we; i_coef_addr = a;
      i_coef_data = cd; i_sat_clr = clr;
      @(posedge i_clk);
      model_edge(v, d, we, a, cd, clr);
      #1;
      check(tag);
   endtask

   function automatic logic signed [15:0] rnd_sample();
      case ($urandom_range(0, 7))
         0:       return 16'sh8000;
         1:       return 16'sh7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      i_rst_n = 1'b1; i_valid = 1'b0; i_data = '0; i_coef_we = 1'b0;
      i_coef_addr = '0; i_coef_data = '0; i_sat_clr = 1'b0;
      model_reset();

      // Reset state, reached asynchronously before any clock edge
      #1 i_rst_n = 1'b0;
      #2 check("reset_async");
      step("reset_ignored", 1'b1, 16'sh7FFF, 1'b1, 2'd0, 16'sh8000, 1'b0);
      step("reset_ignored", 1'b1, 16'sh1234);
      @(negedge i_clk) i_rst_n = 1'b1;

      // Impulse: single output of h3 * 0x7FFF one cycle after the 4th sample
      step("impulse", 1'b1, 16'sh7FFF);
      step("impulse", 1'b1, 16'sh0);
      step("impulse", 1'b1, 16'sh0);
      step("impulse", 1'b1, 16'sh0);
      check_const("impulse_valid", 18'(o_valid), 18'd1);
      check_const("impulse_data", 18'(o_data), 18'h004EF);
      for (int i = 0; i < 8; i++) step("impulse_tail", 1'b1, 16'sh0);

      // DC: constant 0x4000, output every 4th accepted sample
      for (int i = 0; i < 12; i++) begin
         step("dc", 1'b1, 16'sh4000);
         if (i == 3) check_const("dc_first", 18'(o_data), 18'h03FFE);
      end

      // DC with random valid gaps
      for (int i = 0; i < 48; i++) step("dc_gaps", 1'(($urandom_range(0, 2) != 0)), 16'sh4000);
      check_const("dc_gaps_data", 18'(o_data), 18'h03FFE);

      // Random data, gaps, coefficient writes and sat clears
      for (int i = 0; i < 400; i++) begin
         logic signed [15:0] cd;
         cd = ($urandom_range(0, 3) == 0) ? 16'sh8000 : 16'($urandom);
         step("random", 1'(($urandom_range(0, 3) != 0)), rnd_sample(),
              1'(($urandom_range(0, 7) == 0)), 2'($urandom), cd,
              1'(($urandom_range(0, 15) == 0)));
      end

      // Saturation: h0 = 0x8000 against x = 0x8000
      i_rst_n = 1'b0;
      #1 model_reset();
      check("sat_reset");
      @(negedge i_clk) i_rst_n = 1'b1;
      step("sat", 1'b1, 16'sh0, 1'b1, 2'd0, 16'sh8000);
      step("sat", 1'b1, 16'sh0);
      step("sat", 1'b1, 16'sh0);
      step("sat", 1'b1, 16'sh8000);
      check_const("sat_data", 18'(o_data), 18'h07FFF);
      check_const("sat_flag", 18'(o_sat), 18'd1);
      for (int i = 0; i < 5; i++) step("sat_hold", 1'b0, 16'sh0);
      check_const("sat_sticky", 18'(o_sat), 18'd1);
      step("sat_clr", 1'b0, 16'sh0, 1'b0, 2'd0, 16'sh0, 1'b1);
      check_const("sat_cleared", 18'(o_sat), 18'd0);
      // Saturating tap on a non-output phase leaves the flag clear
      step("sat_phase0", 1'b1, 16'sh8000);
      check_const("sat_nonoutput", 18'(o_sat), 18'd0);
      step("sat_win", 1'b1, 16'sh0);
      step("sat_win", 1'b1, 16'sh0);
      // Set and clear together: set wins
      step("sat_win", 1'b1, 16'sh8000, 1'b0, 2'd0, 16'sh0, 1'b1);
      check_const("sat_set_wins", 18'(o_sat), 18'd1);

      // Async reset mid-frame after 2 samples
      step("async_pre", 1'b1, 16'sh1111);
      step("async_pre", 1'b1, 16'sh2222);
      #2 i_rst_n = 1'b0;
      #1;
      check_const("async_data", 18'(o_data), 18'd0);
      check_const("async_sat", 18'(o_sat), 18'd0);
      check_const("async_valid", 18'(o_valid), 18'd0);
      model_reset();
      step("async_held", 1'b1, 16'sh7FFF, 1'b1, 2'd3, 16'sh7FFF, 1'b0);
      @(negedge i_clk) i_rst_n = 1'b1;
      // h0 restored: x[n]=0x7FFF on the 4th new sample gives h0*0x7FFF
      step("async_post", 1'b1, 16'sh0);
      step("async_post", 1'b1, 16'sh0);
      step("async_post", 1'b1, 16'sh0);
      check_const("async_no_early", 18'(o_valid), 18'd0);
      step("async_post", 1'b1, 16'sh7FFF);
      check_const("async_h0_valid", 18'(o_valid), 18'd1);
      check_const("async_h0_data", 18'(o_data), 18'h004EF);
      step("async_tail", 1'b0, 16'sh0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 Parameter NB_INPUT, default 16, input sample width, format S(16,15).
REQ-002 Parameter NB_OUTPUT, default 18, output sample width, format S(18,15).
REQ-003 Parameter DECIM, default 4, decimation ratio; legal range 2..16.
REQ-004 Port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port i_valid, input, 1, i_data qualifier; a sample is accepted on every rising edge with i_valid=1.
REQ-007 Port i_data, input, NB_INPUT, signed input sample.
REQ-008 Port i_coef_we, input, 1, coefficient write strobe.
REQ-009 Port i_coef_addr, input, 2, tap index 0..3.
REQ-010 Port i_coef_data, input, 16, signed S(16,15) coefficient.
REQ-011 Port i_sat_clr, input, 1, synchronous clear of o_sat.
REQ-012 Port o_data, output, NB_OUTPUT, signed decimated filter output, registered.
REQ-013 Port o_valid, output, 1, one-cycle strobe marking a new o_data.
REQ-014 Port o_sat, output, 1, sticky flag: tap saturation occurred.

Function
REQ-015 4-tap FIR: y = h0*x[n] + h1*x[n-1] + h2*x[n-2] + h3*x[n-3]; x[n] is the sample accepted this cycle.
REQ-016 x[n-1..n-3] held in a 3-deep delay line; shifts only on accepted samples; no shift when i_valid=0.
REQ-017 Coefficient registers h0..h3 reset to 0x04F0, 0x3B0F, 0x3B0F, 0x04F0.
REQ-018 i_coef_we=1 writes i_coef_data to h[i_coef_addr] at the edge; new value is used from the next edge on.
REQ-019 Each product is an exact 32-bit S(32,30) value.
REQ-020 Each product is reduced to S(16,15) as follows: if p[31]!=p[30], saturate to 0x7FFF (p>=0) or 0x8000 (p<0); otherwise take p[30:15] (truncation, floor toward -inf).
REQ-021 The four reduced taps are summed at full precision into S(18,15); the adder tree never overflows.
REQ-022 Phase counter runs 0..DECIM-1 and increments on each accepted sample, wrapping DECIM-1 -> 0.
REQ-023 Accepted sample with phase==DECIM-1: o_data <= y (computed with the pre-shift delay line), and o_valid=1 in the following cycle.
REQ-024 Latency is 1 clock from the accepting edge to o_valid/o_data.
REQ-025 o_valid is high for exactly one cycle per output; o_data holds its value between outputs.
REQ-026 o_sat is set when any tap saturates on an output-producing sample; saturation on non-output phases does not set it.
REQ-027 When o_sat set and i_sat_clr occur in the same cycle, set wins.
REQ-028 When a coefficient write and an output-producing sample occur in the same cycle, the old coefficient is used.

Reset
REQ-029 i_rst_n=0 immediately forces o_data=0, o_valid=0, o_sat=0, phase=0, delay line=0 and coefficients to their REQ-017 values, with no clock edge required.
REQ-030 Reset mid-frame discards the partial phase; after release, the first output requires DECIM new accepted samples.
REQ-031 Inputs are ignored while i_rst_n=0.

Verification
REQ-032 Impulse, DECIM=4: samples 0x7FFF,0,0,0 (continuous valid) -> single o_valid 1 cycle after the 4th sample with o_data=0x004EF; subsequent outputs 0.
REQ-033 DC, DECIM=4: constant 0x4000 -> first output 0x03FFE after 4 samples, then every 4th accepted sample.
REQ-034 Valid gaps: the REQ-033 stimulus with random i_valid=0 cycles inserted -> identical o_data sequence; o_valid asserted only after accepted phase-3 samples.
REQ-035 Saturation: write h0=0x8000 after reset, feed 0,0,0,0x8000 -> o_data=0x07FFF and o_sat=1; o_sat stays 1 until a single i_sat_clr pulse, then reads 0.
REQ-036 Async reset: 2 samples accepted, pulse i_rst_n low mid-cycle -> outputs 0 at once, h0 back to 0x04F0; next o_valid only after 4 new samples.
